// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle controller.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_R_EXEC,
    S_R_WB,
    S_IMM_EXEC,
    S_IMM_WB,
    S_BRANCH,
    S_JUMP,
    S_JR,
    S_TRAP
  } state_t;

  // Opcode offsets from the R-type base opcode
  localparam int unsigned OFS_R    = 0;
  localparam int unsigned OFS_LW   = 1;
  localparam int unsigned OFS_SW   = 2;
  localparam int unsigned OFS_BEQ  = 3;
  localparam int unsigned OFS_BLT  = 4;
  localparam int unsigned OFS_SUBI = 5;
  localparam int unsigned OFS_ADDI = 6;
  localparam int unsigned OFS_BEQI = 7;
  localparam int unsigned OFS_J    = 8;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  // One-hot instruction class
  typedef struct packed {
    logic r;
    logic jr;
    logic lw;
    logic sw;
    logic beq;
    logic blt;
    logic subi;
    logic addi;
    logic beqi;
    logic j;
    logic bad;
  } iclass_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode/funct classifier feeding the controller FSM.
module control_decode
  import ctrl_pkg::*;
#(
  parameter int OPW      = 8,
  parameter int FW       = 6,
  parameter int OP_BASE  = 51,
  parameter int JR_FUNCT = 8
) (
  input  logic [OPW-1:0] op,
  input  logic [FW-1:0]  funct,
  output iclass_t        cls
);

  localparam logic [OPW-1:0] OP_R    = OPW'(OP_BASE + OFS_R);
  localparam logic [OPW-1:0] OP_LW   = OPW'(OP_BASE + OFS_LW);
  localparam logic [OPW-1:0] OP_SW   = OPW'(OP_BASE + OFS_SW);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(OP_BASE + OFS_BEQ);
  localparam logic [OPW-1:0] OP_BLT  = OPW'(OP_BASE + OFS_BLT);
  localparam logic [OPW-1:0] OP_SUBI = OPW'(OP_BASE + OFS_SUBI);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(OP_BASE + OFS_ADDI);
  localparam logic [OPW-1:0] OP_BEQI = OPW'(OP_BASE + OFS_BEQI);
  localparam logic [OPW-1:0] OP_J    = OPW'(OP_BASE + OFS_J);
  localparam logic [FW-1:0]  F_JR    = FW'(JR_FUNCT);

  // Map opcode (and funct for R-type) to exactly one class bit
  always_comb begin
    cls = '0;
    case (op)
      OP_R: begin
        cls.jr = (funct == F_JR);
        cls.r  = (funct != F_JR);
      end
      OP_LW:   cls.lw   = 1'b1;
      OP_SW:   cls.sw   = 1'b1;
      OP_BEQ:  cls.beq  = 1'b1;
      OP_BLT:  cls.blt  = 1'b1;
      OP_SUBI: cls.subi = 1'b1;
      OP_ADDI: cls.addi = 1'b1;
      OP_BEQI: cls.beqi = 1'b1;
      OP_J:    cls.j    = 1'b1;
      default: cls.bad  = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FSM controller: sequences fetch/decode/execute/memory/write-back,
// handles memory wait states, traps illegal opcodes and counts retirements.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OPW      = 8,
  parameter int FW       = 6,
  parameter int OP_BASE  = 51,
  parameter int JR_FUNCT = 8,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPW-1:0]   op,
  input  logic [FW-1:0]    funct,
  input  logic             mem_ready,
  input  logic             zero,
  input  logic             lt,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired,
  output logic             illegal
);

  state_t  state, state_n;
  iclass_t cls;

  control_decode #(
    .OPW      (OPW),
    .FW       (FW),
    .OP_BASE  (OP_BASE),
    .JR_FUNCT (JR_FUNCT)
  ) u_decode (
    .op    (op),
    .funct (funct),
    .cls   (cls)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_n;
  end

  // Next-state and control outputs; everything stays 0 while reset is high
  always_comb begin
    state_n    = state;
    pc_write   = 1'b0;
    pc_src     = PCSRC_ALU;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = ALU_OP_ADD;
    instr_done = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_n  = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM_SH;
          if (cls.lw || cls.sw)                     state_n = S_MEM_ADDR;
          else if (cls.r)                           state_n = S_R_EXEC;
          else if (cls.jr)                          state_n = S_JR;
          else if (cls.beq || cls.blt || cls.beqi)  state_n = S_BRANCH;
          else if (cls.addi || cls.subi)            state_n = S_IMM_EXEC;
          else if (cls.j)                           state_n = S_JUMP;
          else                                      state_n = S_TRAP;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          state_n   = cls.lw ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          if (mem_ready) state_n = S_MEM_WB;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
          state_n    = S_FETCH;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_n    = S_FETCH;
          end
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_OP_FUNCT;
          state_n   = S_R_WB;
        end
        S_R_WB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
          state_n    = S_FETCH;
        end
        S_IMM_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = cls.subi ? ALU_OP_SUB : ALU_OP_ADD;
          state_n   = S_IMM_WB;
        end
        S_IMM_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_n    = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = ALU_OP_SUB;
          alu_src_b  = cls.beqi ? SRCB_IMM : SRCB_RT;
          pc_src     = PCSRC_ALUOUT;
          pc_write   = ((cls.beq || cls.beqi) && zero) || (cls.blt && lt);
          instr_done = 1'b1;
          state_n    = S_FETCH;
        end
        S_JUMP: begin
          pc_src     = PCSRC_JUMP;
          pc_write   = 1'b1;
          instr_done = 1'b1;
          state_n    = S_FETCH;
        end
        S_JR: begin
          pc_src     = PCSRC_RS;
          pc_write   = 1'b1;
          instr_done = 1'b1;
          state_n    = S_FETCH;
        end
        S_TRAP:  state_n = S_TRAP;
        default: state_n = S_FETCH;
      endcase
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (reset)           retired <= '0;
    else if (instr_done) retired <= retired + CNT_W'(1);
  end

  // Sticky illegal-opcode flag, set as the FSM enters TRAP
  always_ff @(posedge clk) begin
    if (reset)                               illegal <= 1'b0;
    else if (state == S_DECODE && cls.bad)   illegal <= 1'b1;
  end

endmodule
